stable_timer: RTL and testbench

//   Parametrised stable counter plus software timer for CSR reads (rdcntvl/rdcntvh)
//   and the timer interrupt. A free-running CNT_W-bit counter advances on a prescaled tick.
//   A snapshot register gives coherent two-half reads of the counter.
//   A countdown timer (one-shot or periodic) raises a sticky interrupt to the CSR/exception unit.

---
 rtl/stable_timer.sv | 101 ++++++++++
 tb/tb_stable_timer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/stable_timer.sv
// Free-running stable counter with snapshot register and a one-shot/periodic
// countdown timer that raises a sticky interrupt.
module stable_timer #(
    parameter int CNT_W    = 64,
    parameter int TIMER_W  = 32,
    parameter int PRESCALE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [CNT_W-1:0]   cnt_o,
    input  logic               cnt_snap_i,
    output logic [CNT_W-1:0]   cnt_snap_o,
    input  logic               tcfg_we,
    input  logic [TIMER_W-1:0] tcfg_wdata,
    output logic [TIMER_W-1:0] tcfg_o,
    output logic [TIMER_W-1:0] tval_o,
    input  logic               ticlr_we,
    output logic               timer_int_o
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    typedef enum logic {
        T_IDLE,
        T_RUN
    } timer_state_e;

    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   snap_q, snap_d;
    logic [TIMER_W-1:0] tcfg_q, tcfg_d;
    logic [TIMER_W-1:0] tval_q, tval_d;
    logic               int_q, int_d;
    logic               tick;
    logic               expire;
    logic [TIMER_W-1:0] reload_val;
    timer_state_e       timer_state;

    always_comb begin
        tick      = (pre_cnt_q == PRE_MAX);
        pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
        cnt_d     = tick ? cnt_q + CNT_W'(1) : cnt_q;
        snap_d    = cnt_snap_i ? cnt_q : snap_q;
    end

    // The timer state is derived from config and count; a config write
    // overrides any decrement and suppresses an expiry in the same cycle.
    always_comb begin
        reload_val  = {tcfg_q[TIMER_W-1:2], 2'b00};
        timer_state = (tcfg_q[0] && (tval_q != '0)) ? T_RUN : T_IDLE;
        expire      = 1'b0;
        tcfg_d      = tcfg_q;
        tval_d      = tval_q;
        if (tcfg_we) begin
            tcfg_d = tcfg_wdata;
            tval_d = {tcfg_wdata[TIMER_W-1:2], 2'b00};
        end else if ((timer_state == T_RUN) && tick) begin
            if (tval_q == TIMER_W'(1)) begin
                expire = 1'b1;
                tval_d = tcfg_q[1] ? reload_val : '0;
            end else begin
                tval_d = tval_q - TIMER_W'(1);
            end
        end
    end

    always_comb begin
        int_d = int_q;
        if (expire) begin
            int_d = 1'b1;
        end else if (ticlr_we) begin
            int_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
            cnt_q     <= '0;
            snap_q    <= '0;
            tcfg_q    <= '0;
            tval_q    <= '0;
            int_q     <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            tcfg_q    <= tcfg_d;
            tval_q    <= tval_d;
            int_q     <= int_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign cnt_snap_o  = snap_q;
    assign tcfg_o      = tcfg_q;
    assign tval_o      = tval_q;
    assign timer_int_o = int_q;

endmodule

// File: tb/tb_stable_timer.sv
// Directed bench for stable_timer: three instances (default, PRESCALE=4, CNT_W=8)
// share the stimulus; expected values are hand-computed constants.
module tb_stable_timer;

    logic        clk;
    logic        rst_n;
    logic        cnt_snap_i;
    logic        tcfg_we;
    logic [31:0] tcfg_wdata;
    logic        ticlr_we;

    logic [63:0] cnt_o, cnt_snap_o;
    logic [31:0] tcfg_o, tval_o;
    logic        timer_int_o;

    logic [63:0] p4_cnt_o, p4_cnt_snap_o;
    logic [31:0] p4_tcfg_o, p4_tval_o;
    logic        p4_timer_int_o;

    logic [7:0]  w8_cnt_o, w8_cnt_snap_o;
    logic [31:0] w8_tcfg_o, w8_tval_o;
    logic        w8_timer_int_o;

    int total_checks;
    int bad_checks;

    stable_timer dut (
        .clk(clk), .rst_n(rst_n), .cnt_o(cnt_o), .cnt_snap_i(cnt_snap_i),
        .cnt_snap_o(cnt_snap_o), .tcfg_we(tcfg_we), .tcfg_wdata(tcfg_wdata),
        .tcfg_o(tcfg_o), .tval_o(tval_o), .ticlr_we(ticlr_we), .timer_int_o(timer_int_o)
    );

    stable_timer #(.PRESCALE(4)) dut_p4 (
        .clk(clk), .rst_n(rst_n), .cnt_o(p4_cnt_o), .cnt_snap_i(cnt_snap_i),
        .cnt_snap_o(p4_cnt_snap_o), .tcfg_we(tcfg_we), .tcfg_wdata(tcfg_wdata),
        .tcfg_o(p4_tcfg_o), .tval_o(p4_tval_o), .ticlr_we(ticlr_we),
        .timer_int_o(p4_timer_int_o)
    );

    stable_timer #(.CNT_W(8)) dut_w8 (
        .clk(clk), .rst_n(rst_n), .cnt_o(w8_cnt_o), .cnt_snap_i(cnt_snap_i),
        .cnt_snap_o(w8_cnt_snap_o), .tcfg_we(tcfg_we), .tcfg_wdata(tcfg_wdata),
        .tcfg_o(w8_tcfg_o), .tval_o(w8_tval_o), .ticlr_we(ticlr_we),
        .timer_int_o(w8_timer_int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Drive one cycle's worth of strobes, then return all of them to idle.
    task automatic applyStimulus(input logic snap, input logic we, input logic [31:0] wdata,
                                 input logic clr);
        cnt_snap_i = snap;
        tcfg_we    = we;
        tcfg_wdata = wdata;
        ticlr_we   = clr;
        @(negedge clk);
        cnt_snap_i = 1'b0;
        tcfg_we    = 1'b0;
        tcfg_wdata = '0;
        ticlr_we   = 1'b0;
    endtask

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        rst_n        = 1'b0;
        cnt_snap_i   = 1'b0;
        tcfg_we      = 1'b0;
        tcfg_wdata   = '0;
        ticlr_we     = 1'b0;
        waitCycles(3);

        checkOutput("rst_cnt", cnt_o, 64'd0);
        checkOutput("rst_snap", cnt_snap_o, 64'd0);
        checkOutput("rst_tcfg", {32'd0, tcfg_o}, 64'd0);
        checkOutput("rst_tval", {32'd0, tval_o}, 64'd0);
        checkOutput("rst_int", {63'd0, timer_int_o}, 64'd0);
        checkOutput("rst_p4_cnt", p4_cnt_o, 64'd0);

        rst_n = 1'b1;
        waitCycles(3);
        checkOutput("t1_cnt3", cnt_o, 64'd3);
        checkOutput("t2_p4_cnt_clk3", p4_cnt_o, 64'd0);
        waitCycles(1);
        checkOutput("t2_p4_cnt_clk4", p4_cnt_o, 64'd1);
        waitCycles(1);
        checkOutput("t1_cnt5", cnt_o, 64'd5);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("t1_snap_capture", cnt_snap_o, 64'd5);
        checkOutput("t1_cnt6", cnt_o, 64'd6);
        waitCycles(4);
        checkOutput("t1_cnt10", cnt_o, 64'd10);
        checkOutput("t1_snap_held", cnt_snap_o, 64'd5);
        waitCycles(1);
        checkOutput("t2_p4_cnt_clk11", p4_cnt_o, 64'd2);
        waitCycles(1);
        checkOutput("t2_p4_cnt_clk12", p4_cnt_o, 64'd3);
        checkOutput("t3_w8_cnt12", {56'd0, w8_cnt_o}, 64'd12);

        waitCycles(243);
        checkOutput("t3_w8_max", {56'd0, w8_cnt_o}, 64'hFF);
        waitCycles(1);
        checkOutput("t3_w8_wrap", {56'd0, w8_cnt_o}, 64'h00);
        checkOutput("t3_wide_no_wrap", cnt_o, 64'd256);
        waitCycles(1);
        checkOutput("t3_w8_continue", {56'd0, w8_cnt_o}, 64'h01);

        // One-shot, InitVal=4 -> 16 ticks
        applyStimulus(1'b0, 1'b1, 32'h11, 1'b0);
        checkOutput("t4_tcfg", {32'd0, tcfg_o}, 64'h11);
        checkOutput("t4_tval_load", {32'd0, tval_o}, 64'd16);
        waitCycles(15);
        checkOutput("t4_tval_1", {32'd0, tval_o}, 64'd1);
        checkOutput("t4_int_before", {63'd0, timer_int_o}, 64'd0);
        waitCycles(1);
        checkOutput("t4_int_fire", {63'd0, timer_int_o}, 64'd1);
        checkOutput("t4_tval_zero", {32'd0, tval_o}, 64'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("t4_int_clear", {63'd0, timer_int_o}, 64'd0);
        waitCycles(100);
        checkOutput("t4_no_refire", {63'd0, timer_int_o}, 64'd0);
        checkOutput("t4_tval_idle", {32'd0, tval_o}, 64'd0);

        applyStimulus(1'b0, 1'b1, 32'h01, 1'b0);
        waitCycles(5);
        checkOutput("t4_init0_tval", {32'd0, tval_o}, 64'd0);
        checkOutput("t4_init0_int", {63'd0, timer_int_o}, 64'd0);

        // Periodic, InitVal=2 -> every 8 ticks
        applyStimulus(1'b0, 1'b1, 32'h0B, 1'b0);
        checkOutput("t5_tval_load", {32'd0, tval_o}, 64'd8);
        waitCycles(7);
        checkOutput("t5_int_before", {63'd0, timer_int_o}, 64'd0);
        waitCycles(1);
        checkOutput("t5_int_fire1", {63'd0, timer_int_o}, 64'd1);
        checkOutput("t5_tval_reload1", {32'd0, tval_o}, 64'd8);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("t5_int_clear", {63'd0, timer_int_o}, 64'd0);
        checkOutput("t5_tval_7", {32'd0, tval_o}, 64'd7);
        waitCycles(6);
        checkOutput("t5_tval_1", {32'd0, tval_o}, 64'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("t5_set_beats_clr", {63'd0, timer_int_o}, 64'd1);
        checkOutput("t5_tval_reload2", {32'd0, tval_o}, 64'd8);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("t5_int_clear2", {63'd0, timer_int_o}, 64'd0);
        waitCycles(6);
        checkOutput("t6_tval_1", {32'd0, tval_o}, 64'd1);
        applyStimulus(1'b0, 1'b1, 32'h15, 1'b0);
        checkOutput("t6_we_suppress", {63'd0, timer_int_o}, 64'd0);
        checkOutput("t6_we_tval", {32'd0, tval_o}, 64'd20);
        checkOutput("t6_we_tcfg", {32'd0, tcfg_o}, 64'h15);

        // Raise the interrupt, then rewrite config: interrupt must survive
        applyStimulus(1'b0, 1'b1, 32'h07, 1'b0);
        waitCycles(4);
        checkOutput("t6_int_set", {63'd0, timer_int_o}, 64'd1);
        applyStimulus(1'b0, 1'b1, 32'h09, 1'b0);
        checkOutput("t6_we_keeps_int", {63'd0, timer_int_o}, 64'd1);
        waitCycles(3);
        checkOutput("t6_tval_5", {32'd0, tval_o}, 64'd5);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);

        rst_n = 1'b0;
        waitCycles(1);
        rst_n = 1'b1;
        checkOutput("t6_rst_cnt", cnt_o, 64'd0);
        checkOutput("t6_rst_snap", cnt_snap_o, 64'd0);
        checkOutput("t6_rst_tcfg", {32'd0, tcfg_o}, 64'd0);
        checkOutput("t6_rst_tval", {32'd0, tval_o}, 64'd0);
        checkOutput("t6_rst_int", {63'd0, timer_int_o}, 64'd0);
        waitCycles(2);
        checkOutput("t6_cnt_restart", cnt_o, 64'd2);
        checkOutput("t6_int_after_rst", {63'd0, timer_int_o}, 64'd0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
